uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte producers using round-robin arbitration with optional message locking. It accepts one byte per grant over a valid/ready handshake and issues a single-cycle tx_start with the latched byte. It then waits for tx_done_tick before granting again. It sits between system requesters (command responder, debug printer, status reporter) and the uart_tx/baud-tick pair.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of grant_id (derived; not overridden)
LOCK_TIMEOUT, 65535, clk cycles a locked owner may idle between bytes before the lock is dropped; 0 = never time out

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
req_data  in  8*N_REQ  packed request bytes
req_last  in  N_REQ  byte from requester i ends its message; 0 = hold lock
req_ready  out  N_REQ  one-hot acceptance pulse, combinational from state/req_valid
tx_start  out  1  one-cycle start strobe to uart_tx
tx_din  out  8  byte to uart_tx, stable from tx_start until tx_done_tick
tx_done_tick  in  1  frame-complete pulse from uart_tx
grant_id  out  ID_W  index of current/last owner
busy  out  1  high in SEND and WAIT
lock_abort  out  1  one-cycle pulse when a lock times out

Behaviour:
- Reset (reset_n low, async): state=IDLE, rr_ptr=N_REQ-1, so requester 0 wins first. Also: data_reg=0, grant_id=0, locked=0, timer=0. Outputs: tx_start=0, tx_din=0, req_ready=0, busy=0, lock_abort=0.
- uart_tx is reset from the same source by the top level (inverted to its active-high reset). Reset mid-frame therefore aborts both blocks cleanly. No byte is replayed.
- States: IDLE, SEND, WAIT, HOLD.
- IDLE, unlocked, any req_valid:
  - Pick the first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Same cycle: req_ready[i]=1 (handshake completes).
  - Next edge: data_reg<=byte, grant_id<=i, rr_ptr<=i, locked<=~req_last[i], state<=SEND.
- IDLE, no req_valid: stay, all req_ready=0.
- SEND: tx_start=1 for exactly one cycle, tx_din=data_reg, busy=1, then WAIT.
- WAIT: busy=1, req_ready=0. On tx_done_tick: go to HOLD if locked, else IDLE.
  - tx_done_tick arriving outside WAIT is ignored.
- HOLD: only requester grant_id is eligible. Other req_valid lines are ignored and see req_ready=0.
  - req_valid[grant_id]: req_ready[grant_id]=1. Latch byte, update locked from req_last, clear timer, go to SEND.
  - Otherwise timer increments each cycle.
  - If LOCK_TIMEOUT!=0 and timer reaches LOCK_TIMEOUT-1: lock_abort pulses 1 cycle, locked<=0, state<=IDLE. Arbitration resumes from grant_id+1.
- Latency: request seen in IDLE/HOLD -> tx_start 1 cycle later. Done tick -> next tx_start 2 cycles later at the earliest. uart_tx is idle by then, so tx_start is never lost.
- Single-requester case: round-robin degenerates to back-to-back service of that requester.
- Simultaneous valid on all lines: grants rotate 0,1,2,3,0,... with one byte each, provided req_last=1.
- rr_ptr wraps N_REQ-1 -> 0. Timer width is $clog2(LOCK_TIMEOUT+1) and it saturates rather than wraps.
- req_data/req_last are sampled only on the handshake cycle. Requesters must hold them stable while valid.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE, SEND, WAIT, HOLD as 2-bit), BYTE_W=8, and a function for the modulo-N round-robin search.
- One sub-module, rr_pick. Combinational: inputs req mask and rr_ptr; outputs one-hot grant, index and any_req. This keeps the FSM readable and lets the picker be unit-tested.

Test Plan:
- Reset, then requester 2 sends 0xA5 with last=1 -> req_ready[2] pulse, tx_start 1 cycle later with tx_din=0xA5, grant_id=2. busy stays high until tx_done_tick, then returns to IDLE.
- All four valid, last=1, bytes 0x10..0x13 -> tx_din sequence 0x10,0x11,0x12,0x13,0x10. There is exactly one tx_start per tx_done_tick.
- Requester 1 sends 0x41,0x42,0x43 (last on 0x43) while requester 3 holds 0x99 valid -> 0x41,0x42,0x43 are serialized contiguously, then 0x99.
- LOCK_TIMEOUT=8: requester 0 sends 0x55 with last=0, goes silent, requester 1 is valid -> lock_abort pulses 8 cycles after entering HOLD. Then requester 1's byte is granted.
- reset_n asserted during WAIT -> all outputs 0 immediately (async), state IDLE. After release, requester 0 has priority.
- Spurious tx_done_tick in IDLE with no requests -> no state change, no tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the modulo-N round-robin search used by the picker.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n; 0 if none set.
    function automatic int unsigned rr_search(input logic [MAX_REQ-1:0] req,
                                              input logic [3:0]         ptr,
                                              input int unsigned        n);
        int unsigned idx;
        int unsigned j;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                j = ({28'd0, ptr} + k) % n;
                if (!found && req[j[3:0]]) begin
                    idx   = j;
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant and index of the first
// requester after rr_ptr.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any_req
);

    always_comb begin
        any_req = |req;
        idx     = ID_W'(rr_search(MAX_REQ'(req), 4'(rr_ptr), N_REQ));
        grant   = '0;
        if (any_req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers, with
// per-message locking and an idle timeout on the lock.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    localparam int unsigned ID_W        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_din,
    input  logic                    tx_done_tick,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    lock_abort
);

    localparam int unsigned TIMER_W = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              locked_q, locked_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  owner_sel;
    logic              owner_valid;
    logic              timeout_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        owner_sel           = '0;
        owner_sel[grant_q]  = 1'b1;
        owner_valid         = req_valid[grant_q];
        timeout_hit         = (LOCK_TIMEOUT != 0) &&
                              (timer_q == TIMER_W'(LOCK_TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= ID_W'(N_REQ - 1);
            grant_q  <= '0;
            data_q   <= '0;
            locked_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            locked_q <= locked_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        locked_d = locked_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    data_d   = req_data[{pick_idx, 3'b000} +: BYTE_W];
                    grant_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                    locked_d = ~req_last[pick_idx];
                    timer_d  = '0;
                    state_d  = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                timer_d = '0;
                if (tx_done_tick) begin
                    state_d = locked_q ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (owner_valid) begin
                    data_d   = req_data[{grant_q, 3'b000} +: BYTE_W];
                    locked_d = ~req_last[grant_q];
                    timer_d  = '0;
                    state_d  = SEND;
                end else if (timeout_hit) begin
                    // rr_ptr already equals grant_q, so search restarts at the next requester
                    locked_d = 1'b0;
                    rr_ptr_d = grant_q;
                    timer_d  = '0;
                    state_d  = IDLE;
                end else if (timer_q != {TIMER_W{1'b1}}) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        tx_start   = 1'b0;
        busy       = 1'b0;
        lock_abort = 1'b0;
        case (state_q)
            IDLE: req_ready = pick_grant;
            SEND: begin
                tx_start = 1'b1;
                busy     = 1'b1;
            end
            WAIT: busy = 1'b1;
            HOLD: begin
                if (owner_valid) begin
                    req_ready = owner_sel;
                end
                lock_abort = !owner_valid && timeout_hit;
            end
            default: ;
        endcase
    end

    assign tx_din   = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter with N_REQ=4, LOCK_TIMEOUT=8.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic [1:0]  grant_id;
    logic        busy;
    logic        lock_abort;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .lock_abort   (lock_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        done;
        logic [3:0]  ready;
        logic        start;
        logic [7:0]  din;
        logic [1:0]  grant;
        logic        busy;
        logic        abort;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] data,
                                input logic [3:0] last, input logic done,
                                input logic [3:0] ready, input logic start,
                                input logic [7:0] din, input logic [1:0] grant,
                                input logic b, input logic abort);
        vec_t v;
        v.valid = valid; v.data  = data;  v.last  = last;  v.done = done;
        v.ready = ready; v.start = start; v.din   = din;   v.grant = grant;
        v.busy  = b;     v.abort = abort;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".ready"}, 32'(req_ready), 32'(v.ready));
        check({tag, ".start"}, 32'(tx_start), 32'(v.start));
        check({tag, ".din"}, 32'(tx_din), 32'(v.din));
        check({tag, ".grant"}, 32'(grant_id), 32'(v.grant));
        check({tag, ".busy"}, 32'(busy), 32'(v.busy));
        check({tag, ".abort"}, 32'(lock_abort), 32'(v.abort));
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic run(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        req_valid    = v.valid;
        req_data     = v.data;
        req_last     = v.last;
        tx_done_tick = v.done;
        @(negedge clk);
        check_outputs(tag, v);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset_n      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        #1;
        check_outputs(tag, mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold_cyc;
        reset_n      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        reset_n = 1'b1;

        // Single byte from requester 2.
        tab = {};
        tab.push_back(mk(4'b0100, 32'h00A50000, 4'hF, 0, 4'b0100, 0, 8'h00, 0, 0, 0));
        tab.push_back(mk(4'b0000, 32'h00A50000, 4'hF, 0, 4'b0000, 1, 8'hA5, 2, 1, 0));
        tab.push_back(mk(4'b0000, 32'h00A50000, 4'hF, 0, 4'b0000, 0, 8'hA5, 2, 1, 0));
        tab.push_back(mk(4'b0000, 32'h00A50000, 4'hF, 1, 4'b0000, 0, 8'hA5, 2, 1, 0));
        tab.push_back(mk(4'b0000, 32'h00A50000, 4'hF, 0, 4'b0000, 0, 8'hA5, 2, 0, 0));
        foreach (tab[i]) run($sformatf("t1[%0d]", i), tab[i]);

        do_reset("reset2");

        // All four valid: rotation 0,1,2,3,0, then a locked message from 1 with 3 waiting.
        tab = {};
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0001, 0, 8'h00, 0, 0, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0000, 1, 8'h10, 0, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h10, 0, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0010, 0, 8'h10, 0, 0, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0000, 1, 8'h11, 1, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h11, 1, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0100, 0, 8'h11, 1, 0, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0000, 1, 8'h12, 2, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h12, 2, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b1000, 0, 8'h12, 2, 0, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0000, 1, 8'h13, 3, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h13, 3, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0001, 0, 8'h13, 3, 0, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 0, 4'b0000, 1, 8'h10, 0, 1, 0));
        tab.push_back(mk(4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h10, 0, 1, 0));
        tab.push_back(mk(4'h0, 32'h13121110, 4'hF, 0, 4'b0000, 0, 8'h10, 0, 0, 0));
        tab.push_back(mk(4'b1010, 32'h99004100, 4'b1000, 0, 4'b0010, 0, 8'h10, 0, 0, 0));
        tab.push_back(mk(4'b1010, 32'h99004100, 4'b1000, 0, 4'b0000, 1, 8'h41, 1, 1, 0));
        tab.push_back(mk(4'b1010, 32'h99004100, 4'b1000, 1, 4'b0000, 0, 8'h41, 1, 1, 0));
        tab.push_back(mk(4'b1010, 32'h99004200, 4'b1000, 0, 4'b0010, 0, 8'h41, 1, 0, 0));
        tab.push_back(mk(4'b1010, 32'h99004200, 4'b1000, 0, 4'b0000, 1, 8'h42, 1, 1, 0));
        tab.push_back(mk(4'b1010, 32'h99004200, 4'b1000, 1, 4'b0000, 0, 8'h42, 1, 1, 0));
        tab.push_back(mk(4'b1010, 32'h99004300, 4'b1010, 0, 4'b0010, 0, 8'h42, 1, 0, 0));
        tab.push_back(mk(4'b1010, 32'h99004300, 4'b1010, 0, 4'b0000, 1, 8'h43, 1, 1, 0));
        tab.push_back(mk(4'b1000, 32'h99004300, 4'b1010, 1, 4'b0000, 0, 8'h43, 1, 1, 0));
        tab.push_back(mk(4'b1000, 32'h99000000, 4'b1010, 0, 4'b1000, 0, 8'h43, 1, 0, 0));
        tab.push_back(mk(4'b1000, 32'h99000000, 4'b1010, 0, 4'b0000, 1, 8'h99, 3, 1, 0));
        tab.push_back(mk(4'b0000, 32'h99000000, 4'b1010, 1, 4'b0000, 0, 8'h99, 3, 1, 0));
        tab.push_back(mk(4'b0000, 32'h99000000, 4'b1010, 0, 4'b0000, 0, 8'h99, 3, 0, 0));
        foreach (tab[i]) run($sformatf("t2[%0d]", i), tab[i]);

        // Lock timeout: requester 0 opens a message and goes silent, requester 1 waits.
        run("t4.grant", mk(4'b0011, 32'h00007755, 4'b0010, 0, 4'b0001, 0, 8'h99, 3, 0, 0));
        run("t4.send", mk(4'b0010, 32'h00007755, 4'b0010, 0, 4'b0000, 1, 8'h55, 0, 1, 0));
        run("t4.wait", mk(4'b0010, 32'h00007755, 4'b0010, 1, 4'b0000, 0, 8'h55, 0, 1, 0));
        hold_cyc = -1;
        for (int k = 0; k < 20 && hold_cyc < 0; k++) begin
            @(posedge clk);
            #1;
            tx_done_tick = 1'b0;
            @(negedge clk);
            check("t4.hold_ready", 32'(req_ready), 32'h0);
            check("t4.hold_busy", 32'(busy), 32'h0);
            if (lock_abort) hold_cyc = k;
        end
        check("t4.abort_cycle", hold_cyc, 7);
        run("t4.regrant", mk(4'b0010, 32'h00007755, 4'b0010, 0, 4'b0010, 0, 8'h55, 0, 0, 0));
        run("t4.send1", mk(4'b0000, 32'h00007755, 4'b0010, 0, 4'b0000, 1, 8'h77, 1, 1, 0));
        run("t4.wait1", mk(4'b0000, 32'h00007755, 4'b0010, 1, 4'b0000, 0, 8'h77, 1, 1, 0));
        run("t4.idle", mk(4'b0000, 32'h00007755, 4'b0010, 0, 4'b0000, 0, 8'h77, 1, 0, 0));

        // Reset asserted while waiting for the frame to finish.
        run("t5.grant", mk(4'b0100, 32'h00C30000, 4'hF, 0, 4'b0100, 0, 8'h77, 1, 0, 0));
        run("t5.send", mk(4'b0000, 32'h00C30000, 4'hF, 0, 4'b0000, 1, 8'hC3, 2, 1, 0));
        run("t5.wait", mk(4'b0000, 32'h00C30000, 4'hF, 0, 4'b0000, 0, 8'hC3, 2, 1, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("t5.async", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        run("t5.prio", mk(4'hF, 32'hD4D3D2D1, 4'hF, 0, 4'b0001, 0, 8'h00, 0, 0, 0));
        run("t5.send0", mk(4'h0, 32'hD4D3D2D1, 4'hF, 0, 4'b0000, 1, 8'hD1, 0, 1, 0));
        run("t5.wait0", mk(4'h0, 32'hD4D3D2D1, 4'hF, 1, 4'b0000, 0, 8'hD1, 0, 1, 0));
        run("t5.idle", mk(4'h0, 32'hD4D3D2D1, 4'hF, 0, 4'b0000, 0, 8'hD1, 0, 0, 0));

        // Spurious done ticks in IDLE change nothing; a later request is served normally.
        run("t6.spur0", mk(4'h0, 32'h0, 4'h0, 1, 4'b0000, 0, 8'hD1, 0, 0, 0));
        run("t6.spur1", mk(4'h0, 32'h0, 4'h0, 1, 4'b0000, 0, 8'hD1, 0, 0, 0));
        run("t6.quiet", mk(4'h0, 32'h0, 4'h0, 0, 4'b0000, 0, 8'hD1, 0, 0, 0));
        run("t6.req", mk(4'b0010, 32'h00000E00, 4'hF, 0, 4'b0010, 0, 8'hD1, 0, 0, 0));
        run("t6.send", mk(4'h0, 32'h00000E00, 4'hF, 0, 4'b0000, 1, 8'h0E, 1, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
